// File: rtl/ifu_if.sv
// Fetch-unit bundle: memory fetch port, instruction port toward the exu, redirect input and
// the sticky fault flag. The master modport is the ifu's view; slave is the surrounding system.
interface ifu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        output mem_rsp_ready,
        output inst_valid,
        output inst,
        output inst_pc,
        output fetch_err,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data,
        input  mem_rsp_err,
        input  inst_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        input  mem_rsp_ready,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        input  fetch_err,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data,
        output mem_rsp_err,
        output inst_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding word fetch at a time, presents each word with its PC
// to the exu, and follows redirects by killing any in-flight response.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input logic   clk,
    input logic   rst,
    ifu_if.master bus
);
    typedef enum logic [1:0] {StReq, StWait, StHold, StErr} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        kill_q, kill_d;
    logic        err_q, err_d;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = bus.redirect_pc & ~32'h3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StReq;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            kill_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            kill_q    <= kill_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        kill_d    = kill_q;
        err_d     = err_q;
        unique case (state_q)
            StReq: begin
                if (bus.redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (bus.mem_req_valid && bus.mem_req_ready) begin
                    state_d = StWait;
                    // the word now in flight belongs to the old PC
                    kill_d  = bus.redirect_valid;
                end
            end
            StWait: begin
                if (bus.redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (bus.mem_rsp_valid) begin
                    kill_d = 1'b0;
                    if (kill_q || bus.redirect_valid) begin
                        state_d = StReq;
                    end else if (bus.mem_rsp_err) begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end else begin
                        inst_d    = bus.mem_rsp_data;
                        inst_pc_d = pc_q;
                        state_d   = StHold;
                    end
                end else if (bus.redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            StHold: begin
                // a redirect drops the held word even if the exu takes it this cycle
                if (bus.redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = StReq;
                end else if (bus.inst_ready) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = StReq;
                end
            end
            StErr: begin
                state_d = StErr;
            end
        endcase
    end

    // the request is masked while reset is held so nothing issues before release
    assign bus.mem_req_valid = (state_q == StReq) && !rst;
    assign bus.mem_req_addr  = pc_q;
    assign bus.mem_rsp_ready = (state_q == StWait);
    assign bus.inst_valid    = (state_q == StHold);
    assign bus.inst          = inst_q;
    assign bus.inst_pc       = inst_pc_q;
    assign bus.fetch_err     = err_q;
endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios plus a randomized phase, with a memory responder and an
// instruction-stream reference model (expected PC sequence) checking every consumed word.
module tb_ifu;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ifu_if bus ();

    ifu #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_con = 0;
    int n_fetch = 0;
    int valid_cycles = 0;
    int err_at = 0;
    int lat = 0;
    bit lat_rand = 1'b0;

    // memory responder state
    bit          pending = 1'b0;
    logic [31:0] p_addr = '0;
    int          p_cnt = 0;
    bit          p_err = 1'b0;

    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, run memory + stream model, drive response.
    task automatic tick();
        logic req_fire, rsp_fire, con;
        @(negedge clk);
        cyc++;
        req_fire = bus.mem_req_valid && bus.mem_req_ready;
        rsp_fire = bus.mem_rsp_valid && bus.mem_rsp_ready;
        con      = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
        if (bus.inst_valid) valid_cycles++;
        if (rst) begin
            exp_pc  = RESET_PC;
            pending = 1'b0;
        end else begin
            if (con) begin
                chk("consume_pc", bus.inst_pc, exp_pc);
                chk("consume_data", bus.inst, data_of(exp_pc));
                n_con++;
                exp_pc = exp_pc + 32'd4;
            end
            if (bus.redirect_valid) exp_pc = bus.redirect_pc & ~32'h3;
            if (rsp_fire) pending = 1'b0;
            if (req_fire) begin
                chk1("one_outstanding", pending, 1'b0);
                pending = 1'b1;
                p_addr  = bus.mem_req_addr;
                p_cnt   = lat_rand ? int'($urandom_range(3)) : lat;
                p_err   = (n_fetch + 1 == err_at);
                n_fetch++;
                req_addr_q.push_back(bus.mem_req_addr);
                req_cyc_q.push_back(cyc);
            end else if (pending && p_cnt > 0) begin
                p_cnt--;
            end
        end
        @(posedge clk);
        #1;
        bus.mem_rsp_valid = pending && (p_cnt == 0);
        bus.mem_rsp_data  = pending ? data_of(p_addr) : 32'h0;
        bus.mem_rsp_err   = pending && p_err;
    endtask

    task automatic wait_inst(input string tag, input int max);
        int k = 0;
        while (!bus.inst_valid && k < max) begin
            tick();
            k++;
        end
        chk1(tag, bus.inst_valid, 1'b1);
    endtask

    task automatic wait_reqs(input string tag, input int target, input int max);
        int k = 0;
        while (req_addr_q.size() < target && k < max) begin
            tick();
            k++;
        end
        chk1(tag, req_addr_q.size() >= target, 1'b1);
    endtask

    initial begin
        int base, nreq, c0, vc0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = '0;
        bus.mem_rsp_err    = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // reset values while rst is held
        tick();
        tick();
        chk1("rst_req_valid", bus.mem_req_valid, 1'b0);
        chk1("rst_rsp_ready", bus.mem_rsp_ready, 1'b0);
        chk1("rst_inst_valid", bus.inst_valid, 1'b0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk1("rst_fetch_err", bus.fetch_err, 1'b0);

        // 1: zero-wait memory, exu always ready
        bus.mem_req_ready = 1'b1;
        bus.inst_ready    = 1'b1;
        rst  = 1'b0;
        base = cyc + 1;
        for (int i = 0; i < 9; i++) tick();
        chk("t1_addr0", req_addr_q[0], 32'h8000_0000);
        chk("t1_addr1", req_addr_q[1], 32'h8000_0004);
        chk("t1_addr2", req_addr_q[2], 32'h8000_0008);
        chk("t1_first_cycle", 32'(req_cyc_q[0]), 32'(base));
        chk("t1_space01", 32'(req_cyc_q[1] - req_cyc_q[0]), 32'd3);
        chk("t1_space12", 32'(req_cyc_q[2] - req_cyc_q[1]), 32'd3);
        chk("t1_consumed", 32'(n_con), 32'd3);

        // 2: request stalled, then instruction held
        bus.mem_req_ready = 1'b0;
        nreq = req_addr_q.size();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("t2_stall_valid", bus.mem_req_valid, 1'b1);
            chk("t2_stall_addr", bus.mem_req_addr, 32'h8000_000C);
        end
        chk("t2_no_req", 32'(req_addr_q.size()), 32'(nreq));
        bus.mem_req_ready = 1'b1;
        bus.inst_ready    = 1'b0;
        wait_inst("t2_inst_valid", 10);
        c0 = n_con;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("t2_hold_valid", bus.inst_valid, 1'b1);
            chk("t2_hold_inst", bus.inst, data_of(32'h8000_000C));
            chk("t2_hold_pc", bus.inst_pc, 32'h8000_000C);
        end
        chk("t2_not_consumed", 32'(n_con), 32'(c0));

        // 3: redirect in HOLD while exu is ready (low bits must be ignored)
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_1001;
        tick();
        bus.redirect_valid = 1'b0;
        chk("t3_dropped", 32'(n_con), 32'(c0));
        chk1("t3_inst_valid", bus.inst_valid, 1'b0);
        chk1("t3_req_valid", bus.mem_req_valid, 1'b1);
        chk("t3_req_addr", bus.mem_req_addr, 32'h8000_1000);

        // 4: redirect while waiting on a slow response
        lat = 4;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        vc0  = valid_cycles;
        nreq = req_addr_q.size();
        wait_reqs("t4_new_req", nreq + 1, 15);
        chk("t4_addr", req_addr_q[nreq], 32'h8000_0100);
        chk("t4_no_inst", 32'(valid_cycles), 32'(vc0));
        lat = 0;
        wait_inst("t4_inst_valid", 10);
        chk("t4_inst_pc", bus.inst_pc, 32'h8000_0100);

        // 5: access fault on the second upcoming fetch
        err_at = n_fetch + 2;
        c0 = n_con;
        for (int k = 0; k < 20 && !bus.fetch_err; k++) tick();
        chk1("t5_fetch_err", bus.fetch_err, 1'b1);
        chk1("t5_no_inst", bus.inst_valid, 1'b0);
        chk("t5_consumed", 32'(n_con - c0), 32'd2);
        nreq = req_addr_q.size();
        for (int i = 0; i < 5; i++) begin
            bus.redirect_valid = (i == 1);
            bus.redirect_pc    = 32'h8000_2000;
            tick();
            chk1("t5_sticky", bus.fetch_err, 1'b1);
            chk1("t5_req_quiet", bus.mem_req_valid, 1'b0);
        end
        bus.redirect_valid = 1'b0;
        chk("t5_no_req", 32'(req_addr_q.size()), 32'(nreq));
        err_at = 0;
        rst = 1'b1;
        tick();
        chk1("t5_rst_clears", bus.fetch_err, 1'b0);
        rst = 1'b0;

        // 6: PC wrap, then reset asserted mid-WAIT
        bus.mem_req_ready  = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        chk("t6_prehs_addr", bus.mem_req_addr, 32'hFFFF_FFFC);
        bus.mem_req_ready = 1'b1;
        bus.inst_ready    = 1'b1;
        nreq = req_addr_q.size();
        wait_reqs("t6_reqs", nreq + 2, 20);
        chk("t6_addr_top", req_addr_q[nreq], 32'hFFFF_FFFC);
        chk("t6_addr_wrap", req_addr_q[nreq + 1], 32'h0000_0000);
        chk1("t6_in_wait", bus.mem_rsp_ready, 1'b1);
        rst = 1'b1;
        #1;
        chk1("t6_rst_req_valid", bus.mem_req_valid, 1'b0);
        chk1("t6_rst_rsp_ready", bus.mem_rsp_ready, 1'b0);
        chk1("t6_rst_inst_valid", bus.inst_valid, 1'b0);
        chk("t6_rst_inst", bus.inst, 32'h0);
        chk("t6_rst_inst_pc", bus.inst_pc, 32'h0);
        chk1("t6_rst_fetch_err", bus.fetch_err, 1'b0);
        tick();
        rst = 1'b0;

        // randomized traffic against the stream model
        lat_rand = 1'b1;
        c0 = n_con;
        for (int i = 0; i < 1500; i++) begin
            bus.mem_req_ready  = ($urandom_range(3) != 0);
            bus.inst_ready     = ($urandom_range(1) == 1);
            bus.redirect_valid = ($urandom_range(15) == 0);
            bus.redirect_pc    = $urandom;
            tick();
        end
        bus.redirect_valid = 1'b0;
        chk1("rand_progress", (n_con - c0) > 50, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
